// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and the datapath: instruction and
// memory-status inputs to the sequencer, all control strobes back out.
//
// Handshake: Mem_ready is a single-cycle qualifier from memory. The
// sequencer keeps Read high for the whole fetch-wait and advances on the
// rising edge where Mem_ready=1. There is no back-pressure on Mem_ready.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        Stop;
    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        Cout;
    logic        MARin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        Zin;
    logic        IncPC;
    logic        Read;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;
    logic [4:0]  operation;
    logic        Run;
    logic        Illegal;

    // Sequencer side
    modport master (
        input  IR, Mem_ready, Stop,
        output PCout, Zlowout, MDRout, Cout,
        output MARin, PCin, MDRin, IRin, Yin, Zin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        output operation, Run, Illegal
    );

    // Datapath side
    modport slave (
        output IR, Mem_ready, Stop,
        input  PCout, Zlowout, MDRout, Cout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        input  operation, Run, Illegal
    );
endinterface

// File: rtl/control_sequencer.sv
// Moore fetch/decode/execute control unit driving the datapath strobes.
// Fetch is T0..T2 (with a memory wait in T1), T3D decodes the opcode,
// ALU instructions execute in T3..T5. Stop is honoured only at instruction
// boundaries; HALT is left only through Reset_n.
module control_sequencer #(
    parameter int             OPW     = 5,
    parameter logic [OPW-1:0] NOP_OP  = 5'b11010,
    parameter logic [OPW-1:0] HALT_OP = 5'b11011
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    control_sequencer_if.master        bus,
    output logic [3:0]                 o_dbg_state
);

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01011;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01110;

    // T1 is the first fetch-wait cycle (PC load); T1W repeats the wait
    // without PCin so the PC is not re-incremented while memory stalls.
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T1W  = 4'd3,
        S_T2   = 4'd4,
        S_T3D  = 4'd5,
        S_T3   = 4'd6,
        S_T4   = 4'd7,
        S_T5   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [OPW-1:0] r_op;
    logic [OPW-1:0] w_opcode;
    logic           w_dec_alu_r;
    logic           w_dec_alu_i;
    logic           w_exe_alu_r;

    assign w_opcode    = bus.IR[31 -: OPW];
    assign w_dec_alu_r = (w_opcode >= OP_ADD)  && (w_opcode <= OP_ROL);
    assign w_dec_alu_i = (w_opcode >= OP_ADDI) && (w_opcode <= OP_ORI);
    assign w_exe_alu_r = (r_op >= OP_ADD) && (r_op <= OP_ROL);
    assign o_dbg_state = r_state;

    // State register; reset forces RST so every strobe drops at once
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode captured at decode so T4 uses a stable copy of the instruction
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_op <= '0;
        end else if (r_state == S_T3D) begin
            r_op <= w_opcode;
        end
    end

    // Next-state and strobe decode from the current state
    always_comb begin
        w_next        = r_state;
        bus.PCout     = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.MDRout    = 1'b0;
        bus.Cout      = 1'b0;
        bus.MARin     = 1'b0;
        bus.PCin      = 1'b0;
        bus.MDRin     = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Read      = 1'b0;
        bus.Gra       = 1'b0;
        bus.Grb       = 1'b0;
        bus.Grc       = 1'b0;
        bus.Rin       = 1'b0;
        bus.Rout      = 1'b0;
        bus.operation = '0;
        bus.Run       = 1'b0;
        bus.Illegal   = 1'b0;
        case (r_state)
            S_RST: begin
                w_next = S_T0;
            end
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                bus.Run   = 1'b1;
                w_next    = S_T1;
            end
            S_T1, S_T1W: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = (r_state == S_T1);
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.Run     = 1'b1;
                w_next      = bus.Mem_ready ? S_T2 : S_T1W;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                bus.Run    = 1'b1;
                w_next     = S_T3D;
            end
            S_T3D: begin
                bus.Run = 1'b1;
                if (w_dec_alu_r || w_dec_alu_i) begin
                    w_next = S_T3;
                end else if (w_opcode == NOP_OP) begin
                    w_next = bus.Stop ? S_HALT : S_T0;
                end else if (w_opcode == HALT_OP) begin
                    w_next = S_HALT;
                end else begin
                    bus.Illegal = 1'b1;
                    w_next      = bus.Stop ? S_HALT : S_T0;
                end
            end
            S_T3: begin
                bus.Grb  = 1'b1;
                bus.Rout = 1'b1;
                bus.Yin  = 1'b1;
                bus.Run  = 1'b1;
                w_next   = S_T4;
            end
            S_T4: begin
                bus.Zin = 1'b1;
                bus.Run = 1'b1;
                if (w_exe_alu_r) begin
                    bus.Grc       = 1'b1;
                    bus.Rout      = 1'b1;
                    bus.operation = r_op;
                end else begin
                    bus.Cout = 1'b1;
                    case (r_op)
                        OP_ADDI: bus.operation = OP_ADD;
                        OP_ANDI: bus.operation = OP_AND;
                        OP_ORI:  bus.operation = OP_OR;
                        default: bus.operation = '0;
                    endcase
                end
                w_next = S_T5;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                bus.Gra     = 1'b1;
                bus.Rin     = 1'b1;
                bus.Run     = 1'b1;
                w_next      = bus.Stop ? S_HALT : S_T0;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_T0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. Each instruction is turned into the list of
// per-cycle strobe vectors it must produce (from opcode, memory wait length
// and Stop level); a compare process checks the DUT against that list every
// cycle. Directed cases come first, then randomized instructions, waits,
// Stop requests and mid-instruction resets.
module tb_control_sequencer;

    localparam logic [23:0] M_PCOUT   = 24'd1 << 0;
    localparam logic [23:0] M_ZLOWOUT = 24'd1 << 1;
    localparam logic [23:0] M_MDROUT  = 24'd1 << 2;
    localparam logic [23:0] M_COUT    = 24'd1 << 3;
    localparam logic [23:0] M_MARIN   = 24'd1 << 4;
    localparam logic [23:0] M_PCIN    = 24'd1 << 5;
    localparam logic [23:0] M_MDRIN   = 24'd1 << 6;
    localparam logic [23:0] M_IRIN    = 24'd1 << 7;
    localparam logic [23:0] M_YIN     = 24'd1 << 8;
    localparam logic [23:0] M_ZIN     = 24'd1 << 9;
    localparam logic [23:0] M_INCPC   = 24'd1 << 10;
    localparam logic [23:0] M_READ    = 24'd1 << 11;
    localparam logic [23:0] M_GRA     = 24'd1 << 12;
    localparam logic [23:0] M_GRB     = 24'd1 << 13;
    localparam logic [23:0] M_GRC     = 24'd1 << 14;
    localparam logic [23:0] M_RIN     = 24'd1 << 15;
    localparam logic [23:0] M_ROUT    = 24'd1 << 16;
    localparam logic [23:0] M_RUN     = 24'd1 << 17;
    localparam logic [23:0] M_ILL     = 24'd1 << 18;

    localparam logic [23:0] V_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
    localparam logic [23:0] V_T1 = M_ZLOWOUT | M_READ | M_MDRIN | M_RUN;
    localparam logic [23:0] V_T2 = M_MDROUT | M_IRIN | M_RUN;
    localparam logic [23:0] V_T3 = M_GRB | M_ROUT | M_YIN | M_RUN;
    localparam logic [23:0] V_T4 = M_ZIN | M_RUN;
    localparam logic [23:0] V_T5 = M_ZLOWOUT | M_GRA | M_RIN | M_RUN;

    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef struct packed {
        logic [23:0] v;
        logic        mr;
        logic        st;
    } ent_t;

    logic        Clock;
    logic        Reset_n;
    logic [3:0]  dbg_state;
    logic [23:0] exp_q[$];
    ent_t        plan_q[$];
    int          n_cmp;
    int          n_err;

    control_sequencer_if cs_if();

    control_sequencer dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .bus         (cs_if),
        .o_dbg_state (dbg_state)
    );

    // Clock and reset
    initial begin
        Clock   = 1'b0;
        Reset_n = 1'b0;
    end
    always #5 Clock = ~Clock;

    function automatic logic [23:0] dut_vec();
        return {cs_if.operation, cs_if.Illegal, cs_if.Run, cs_if.Rout, cs_if.Rin,
                cs_if.Grc, cs_if.Grb, cs_if.Gra, cs_if.Read, cs_if.IncPC, cs_if.Zin,
                cs_if.Yin, cs_if.IRin, cs_if.MDRin, cs_if.PCin, cs_if.MARin,
                cs_if.Cout, cs_if.MDRout, cs_if.Zlowout, cs_if.PCout};
    endfunction

    function automatic logic [4:0] alu_op(input logic [4:0] op);
        case (op)
            5'd12:   return 5'b00011;
            5'd13:   return 5'b00101;
            5'd14:   return 5'b00110;
            default: return op;
        endcase
    endfunction

    // Scoreboard: one expected vector per cycle, checked mid-cycle
    always @(negedge Clock) begin
        logic [23:0] e;
        logic [23:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = dut_vec();
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL strobes t=%0t got=%h exp=%h", $time, a, e);
            end
        end
    end

    task automatic check_pin(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Build the cycle-by-cycle plan for one instruction
    task automatic plan_instr(input logic [4:0] op, input int w, input bit stop_b,
                              input bit noise, input int stop_from, output bit halted);
        logic [23:0] vq[$];
        bit   alu_r;
        bit   alu_i;
        bit   known;
        int   bidx;
        ent_t e;
        alu_r = (op >= 5'd3) && (op <= 5'd11);
        alu_i = (op >= 5'd12) && (op <= 5'd14);
        known = alu_r || alu_i || (op == OP_NOP) || (op == OP_HALT);
        vq.push_back(V_T0);
        vq.push_back(V_T1 | M_PCIN);
        for (int k = 0; k < w; k++) vq.push_back(V_T1);
        vq.push_back(V_T2);
        vq.push_back(known ? M_RUN : (M_RUN | M_ILL));
        bidx = vq.size() - 1;
        if (alu_r || alu_i) begin
            vq.push_back(V_T3);
            vq.push_back(V_T4 | (alu_r ? (M_GRC | M_ROUT) : M_COUT) | {alu_op(op), 19'd0});
            vq.push_back(V_T5);
            bidx = vq.size() - 1;
        end
        if (op == OP_HALT) bidx = -1;
        halted = (op == OP_HALT);
        plan_q.delete();
        for (int i = 0; i < vq.size(); i++) begin
            e.v = vq[i];
            if (i >= 1 && i <= w + 1) e.mr = (i == w + 1);
            else e.mr = noise ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stop_from >= 0) e.st = (i >= stop_from);
            else if (i == bidx) e.st = stop_b;
            else e.st = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (i == bidx && e.st) halted = 1'b1;
            plan_q.push_back(e);
        end
    endtask

    // Driver: play the plan, optionally stopping before entry 'cut'
    task automatic run_plan(input logic [31:0] ir, input int cut);
        for (int i = 0; i < plan_q.size(); i++) begin
            if (cut >= 0 && i >= cut) break;
            @(posedge Clock);
            #1;
            if (i == 0) cs_if.IR = ir;
            cs_if.Mem_ready = plan_q[i].mr;
            cs_if.Stop      = plan_q[i].st;
            exp_q.push_back(plan_q[i].v);
        end
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
            cs_if.Mem_ready = 1'($urandom_range(0, 1));
            cs_if.Stop      = 1'($urandom_range(0, 1));
            exp_q.push_back(24'd0);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
            Reset_n         = 1'b0;
            cs_if.Mem_ready = 1'b0;
            cs_if.Stop      = 1'b0;
            exp_q.push_back(24'd0);
        end
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        exp_q.push_back(24'd0);
    endtask

    // Watchdog
    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog t=%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Stimulus
    initial begin
        bit          h;
        logic [4:0]  op;
        int          w;
        int          cut;
        int          sel;
        n_cmp           = 0;
        n_err           = 0;
        cs_if.IR        = 32'd0;
        cs_if.Mem_ready = 1'b0;
        cs_if.Stop      = 1'b0;

        do_reset(3);

        // add R4,R3,R7, no wait
        plan_instr(5'b00011, 0, 1'b0, 1'b0, -1, h);
        check_pin("add_len",   24'(plan_q.size()), 24'd7);
        check_pin("add_t0",    plan_q[0].v, 24'h020611);
        check_pin("add_t4",    plan_q[5].v, 24'h1B4200);
        check_pin("add_t5",    plan_q[6].v, 24'h029002);
        run_plan(32'h1A1B8000, -1);

        // add with three wait cycles in fetch
        plan_instr(5'b00011, 3, 1'b0, 1'b0, -1, h);
        check_pin("wait_len",  24'(plan_q.size()), 24'd10);
        check_pin("wait_t1a",  plan_q[1].v, 24'h020862);
        check_pin("wait_t1b",  plan_q[2].v, 24'h020842);
        check_pin("wait_t1d",  plan_q[4].v, 24'h020842);
        check_pin("wait_t2",   plan_q[5].v, 24'h020084);
        run_plan(32'h1A1B8000, -1);

        // addi R2,R1,5
        plan_instr(5'b01100, 0, 1'b0, 1'b0, -1, h);
        check_pin("addi_t4",   plan_q[5].v, 24'h1A0208);
        run_plan(32'h61080005, -1);

        // NOP then illegal
        plan_instr(OP_NOP, 0, 1'b0, 1'b0, -1, h);
        check_pin("nop_len",   24'(plan_q.size()), 24'd4);
        check_pin("nop_t3d",   plan_q[3].v, 24'h020000);
        run_plan(32'hD0000000, -1);
        plan_instr(5'b11111, 1, 1'b0, 1'b0, -1, h);
        check_pin("ill_t3d",   plan_q[4].v, 24'h060000);
        run_plan(32'hF8000000, -1);

        // Stop raised during T3 of an add: finishes, then halts
        plan_instr(5'b00011, 0, 1'b0, 1'b0, 4, h);
        check_pin("stop_halt", {23'd0, h}, 24'd1);
        run_plan(32'h1A1B8000, -1);
        halt_cycles(5);
        do_reset(1);

        // HALT opcode stays halted
        plan_instr(OP_HALT, 0, 1'b0, 1'b0, -1, h);
        run_plan(32'hD8000000, -1);
        halt_cycles(12);
        do_reset(2);

        // NOP with Stop at the boundary halts
        plan_instr(OP_NOP, 0, 1'b1, 1'b0, -1, h);
        run_plan(32'hD0000000, -1);
        halt_cycles(3);
        do_reset(1);

        // Reset during a T1 wait, then restart cleanly
        plan_instr(5'b00011, 2, 1'b0, 1'b0, -1, h);
        run_plan(32'h1A1B8000, 2);
        do_reset(2);
        plan_instr(5'b00100, 0, 1'b0, 1'b0, -1, h);
        run_plan(32'h21000000, -1);

        // Randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)       op = 5'($urandom_range(3, 11));
            else if (sel < 7)  op = 5'($urandom_range(12, 14));
            else if (sel == 7) op = OP_NOP;
            else if (sel == 8) op = 5'($urandom_range(0, 31));
            else               op = ($urandom_range(0, 1) == 0) ? OP_HALT : 5'($urandom_range(0, 31));
            w = $urandom_range(0, 3);
            plan_instr(op, w, ($urandom_range(0, 7) == 0), 1'b1, -1, h);
            cut = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, plan_q.size() - 1)) : -1;
            run_plan({op, 27'($urandom)}, cut);
            if (cut >= 0) begin
                do_reset($urandom_range(1, 2));
            end else if (h) begin
                halt_cycles($urandom_range(2, 6));
                do_reset($urandom_range(1, 3));
            end
        end

        repeat (3) @(negedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
